// File: rtl/h80_uart_tx_arbiter.sv
// h80_uart_tx_arbiter: round-robin share of one UART transmitter among NUM_REQ byte producers.
// Latency: req_valid to req_ready 2 cycles from idle, uart_en rises the cycle after req_ready.
// Backpressure: req_ready stays low while the UART is busy or another owner holds grant; UART_ARB_LOCK_EN keeps messages contiguous.
module h80_uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           uart_data,
    output logic                 uart_en,
    input  logic                 uart_busy,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 timeout_err,
    input  logic                 err_clr
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DRAIN, S_NEXT} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d, rr_q, rr_d;
    logic [IDX_W-1:0]   pick_idx, cand, owner_inc;
    logic               pick_vld;
    logic [NUM_REQ-1:0] grant_d;
    logic [7:0]         uart_data_d, timer_q, timer_d;
    logic               uart_en_d, timeout_err_d;
`ifdef UART_ARB_LOCK_EN
    logic               last_q, last_d, lock_q, lock_d;
`else
    logic               unused_last;
    assign unused_last = ^req_last;
`endif

    // First valid requester at or after the rotation pointer.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign owner_inc = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
    assign req_ready = (state_q == S_LOAD) ? (grant & req_valid) : '0;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_d          = rr_q;
        grant_d       = grant;
        uart_data_d   = uart_data;
        uart_en_d     = uart_en;
        timer_d       = timer_q;
        timeout_err_d = timeout_err & ~err_clr;
`ifdef UART_ARB_LOCK_EN
        last_d        = last_q;
        lock_d        = lock_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_vld && !uart_busy) begin
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    state_d           = S_LOAD;
                end
            end
            S_LOAD: begin
                if (req_valid[owner_q]) begin
                    uart_data_d = req_data[{owner_q, 3'b000} +: 8];
                    uart_en_d   = 1'b1;
                    timer_d     = '0;
                    state_d     = S_START;
`ifdef UART_ARB_LOCK_EN
                    last_d      = req_last[owner_q];
`endif
                end else begin
`ifdef UART_ARB_LOCK_EN
                    // A locked owner between message bytes keeps the UART.
                    if (!lock_q) begin
                        grant_d = '0;
                        state_d = S_IDLE;
                    end
`else
                    grant_d = '0;
                    state_d = S_IDLE;
`endif
                end
            end
            S_START: begin
                if (uart_busy) begin
                    uart_en_d = 1'b0;
                    state_d   = S_DRAIN;
                end else if (timer_q == 8'(BUSY_TIMEOUT - 1)) begin
                    // Byte is treated as consumed; move on so service never stalls.
                    uart_en_d     = 1'b0;
                    timeout_err_d = 1'b1;
                    grant_d       = '0;
                    rr_d          = owner_inc;
                    state_d       = S_IDLE;
`ifdef UART_ARB_LOCK_EN
                    lock_d        = 1'b0;
`endif
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_DRAIN: begin
                if (!uart_busy) state_d = S_NEXT;
            end
            S_NEXT: begin
`ifdef UART_ARB_LOCK_EN
                if (!last_q) begin
                    lock_d  = 1'b1;
                    state_d = S_LOAD;
                end else begin
                    lock_d  = 1'b0;
                    rr_d    = owner_inc;
                    grant_d = '0;
                    state_d = S_IDLE;
                end
`else
                rr_d    = owner_inc;
                grant_d = '0;
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            rr_q        <= '0;
            grant       <= '0;
            uart_data   <= '0;
            uart_en     <= 1'b0;
            timer_q     <= '0;
            timeout_err <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            last_q      <= 1'b0;
            lock_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            grant       <= grant_d;
            uart_data   <= uart_data_d;
            uart_en     <= uart_en_d;
            timer_q     <= timer_d;
            timeout_err <= timeout_err_d;
`ifdef UART_ARB_LOCK_EN
            last_q      <= last_d;
            lock_q      <= lock_d;
`endif
        end
    end
endmodule

// File: tb/tb_h80_uart_tx_arbiter.sv
// Bench for h80_uart_tx_arbiter: per-requester byte queues, a UART responder, and a
// scoreboard fed on each accepted byte and drained on each uart_en rise.
module tb_h80_uart_tx_arbiter;
    localparam int NR  = 4;
    localparam int TMO = 8;
    localparam int U_AUTO  = 0;
    localparam int U_DEAD  = 1;
    localparam int U_FORCE = 2;

    typedef struct packed { logic [7:0] data; logic last; } item_t;
    typedef struct packed { logic [1:0] id; logic [7:0] data; } exp_t;

    logic            clk;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [7:0]      uart_data;
    logic            uart_en;
    logic            uart_busy;
    logic [NR-1:0]   grant;
    logic            timeout_err;
    logic            err_clr;

    h80_uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .uart_data(uart_data),
        .uart_en(uart_en), .uart_busy(uart_busy), .grant(grant),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    item_t       src_q [NR][$];
    exp_t        exp_q [$];
    logic [7:0]  log_q [$];
    int          umode = U_AUTO;
    logic        force_busy = 1'b0;
    int          gap_max = 0;
    int          m_rr, m_owner;
    logic        m_locked, prev_en;
    logic [NR-1:0] prev_valid;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int start);
        logic [1:0] j;
        for (int k = 0; k < NR; k++) begin
            j = 2'(start + k);
            if (v[j]) return int'(j);
        end
        return -1;
    endfunction

    function automatic bit src_empty();
        for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_item(input int i, input logic [7:0] d, input logic l);
        item_t it;
        it.data = d;
        it.last = l;
        src_q[i].push_back(it);
    endtask

    // Requester side: present queue heads, hold until accepted.
    initial begin : driver
        logic [NR-1:0] acc;
        int gap [NR];
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < NR; i++) gap[i] = 0;
        forever begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    req_valid[i] = 1'b0;
                    gap[i] = $urandom_range(0, gap_max);
                end
                if (!req_valid[i] && src_q[i].size() > 0) begin
                    if (gap[i] > 0) gap[i]--;
                    else begin
                        req_valid[i]         = 1'b1;
                        req_data[8*i +: 8]   = src_q[i][0].data;
                        req_last[i]          = src_q[i][0].last;
                    end
                end
            end
        end
    end

    // Transmitter model: busy after a short delay, for a random frame length.
    initial begin : uart_model
        int d, l;
        uart_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (umode == U_FORCE) uart_busy = force_busy;
            else begin
                uart_busy = 1'b0;
                if (umode == U_AUTO && uart_en) begin
                    d = $urandom_range(1, 3);
                    l = $urandom_range(2, 8);
                    repeat (d - 1) begin @(posedge clk); #1; end
                    uart_busy = 1'b1;
                    repeat (l) begin @(posedge clk); #1; end
                    uart_busy = 1'b0;
                end
            end
        end
    end

    // Monitor: rotation model on accepts, scoreboard compare on transmit start.
    initial begin : monitor
        int id, exp_id;
        item_t it;
        exp_t e;
        m_rr = 0; m_owner = 0; m_locked = 1'b0; prev_en = 1'b0; prev_valid = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_rr = 0; m_locked = 1'b0; prev_en = 1'b0; prev_valid = '0;
            end else begin
                if (req_ready != '0) begin
                    check("ready_onehot", $countones(req_ready), 1);
                    id = 0;
                    for (int i = 0; i < NR; i++) if (req_ready[i]) id = i;
                    exp_id = m_locked ? m_owner : rr_pick(prev_valid, m_rr);
                    check("rr_winner", id, exp_id);
                    if (src_q[id].size() == 0) check("ready_src_nonempty", src_q[id].size(), 1);
                    else begin
                        it = src_q[id][0];
                        e.id = 2'(id);
                        e.data = it.data;
                        exp_q.push_back(e);
                        m_owner = id;
                        m_rr = (id + 1) % NR;
`ifdef UART_ARB_LOCK_EN
                        m_locked = !it.last;
`else
                        m_locked = 1'b0;
`endif
                    end
                end
                if (uart_en && !prev_en) begin
                    if (exp_q.size() == 0) check("sb_unexpected_tx", exp_q.size(), 1);
                    else begin
                        e = exp_q.pop_front();
                        check("tx_data", uart_data, e.data);
                        check("tx_grant", grant, 32'd1 << e.id);
                        log_q.push_back(uart_data);
                    end
                end
                prev_en = uart_en;
                prev_valid = req_valid;
            end
        end
    end

    task automatic wait_idle(input string tag);
        int c = 0;
        while (c < 3000 && !(src_empty() && exp_q.size() == 0 && grant == '0 && !uart_en && !uart_busy)) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_idle"}, (c < 3000), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_log(input string tag, input int n, input int budget);
        int c = 0;
        while (log_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_count"}, log_q.size(), n);
    endtask

    task automatic wait_en(input string tag);
        int c = 0;
        while (!uart_en && c < 40) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_en_seen"}, uart_en, 1);
    endtask

    task automatic en_length(output int n);
        n = 0;
        while (uart_en && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        logic [7:0] t4_exp [4];
        int lat, c, n, total, left;
        bit seen;
        reset   = 1'b1;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_uart_en", uart_en, 0);
        check("rst_uart_data", uart_data, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_timeout_err", timeout_err, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // All requesters continuously valid: strict rotation.
        log_q.delete();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < NR; i++) push_item(i, 8'(i * 17), 1'b1);
        wait_log("t2", 12, 2000);
        for (int k = 0; k < 12 && k < log_q.size(); k++)
            check($sformatf("t2_order_%0d", k), log_q[k], 8'((k % 4) * 17));
        wait_idle("t2");

        // Message of three bytes from req0 against a single byte from req1.
        do_reset();
`ifdef UART_ARB_LOCK_EN
        t4_exp = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
`else
        t4_exp = '{8'hA0, 8'hB0, 8'hA1, 8'hA2};
`endif
        log_q.delete();
        push_item(0, 8'hA0, 1'b0);
        push_item(0, 8'hA1, 1'b0);
        push_item(0, 8'hA2, 1'b1);
        push_item(1, 8'hB0, 1'b1);
        wait_log("t4", 4, 1000);
        for (int k = 0; k < 4 && k < log_q.size(); k++)
            check($sformatf("t4_order_%0d", k), log_q[k], t4_exp[k]);
        wait_idle("t4");

        // Single byte latency.
        push_item(0, 8'h41, 1'b1);
        c = 0;
        while (!req_valid[0] && c < 20) begin @(negedge clk); c++; end
        lat = 1;
        do begin @(negedge clk); lat++; end while (req_ready[0] !== 1'b1 && lat < 20);
        check("t1_ready_latency", lat, 2);
        @(negedge clk);
        check("t1_en_after_ready", uart_en, 1);
        check("t1_uart_data", uart_data, 8'h41);
        wait_idle("t1");
        check("t1_grant_release", grant, 0);

        // Busy held in idle blocks arbitration without error.
        umode = U_FORCE;
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        push_item(3, 8'hC3, 1'b1);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (req_ready != '0) seen = 1'b1;
        end
        check("t6_no_ready_while_busy", seen, 0);
        umode = U_AUTO;
        c = 0;
        while (req_ready[3] !== 1'b1 && c < 6) begin @(negedge clk); c++; end
        check("t6_ready_after_busy", req_ready[3], 1);
        wait_idle("t6");
        check("t6_no_err", timeout_err, 0);

        // Transmitter never answers: timeout, sticky error, clear.
        umode = U_DEAD;
        push_item(0, 8'h5A, 1'b1);
        wait_en("t3a");
        en_length(n);
        check("t3a_en_cycles", n, TMO);
        check("t3a_err_set", timeout_err, 1);
        repeat (5) @(negedge clk);
        check("t3a_err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t3a_err_clr", timeout_err, 0);
        wait_idle("t3a");

        // Timeout while err_clr is held: the set wins, next requester still served.
        log_q.delete();
        err_clr = 1'b1;
        push_item(1, 8'h6B, 1'b1);
        push_item(2, 8'h7C, 1'b1);
        wait_en("t3b");
        en_length(n);
        check("t3b_en_cycles", n, TMO);
        check("t3b_set_wins", timeout_err, 1);
        umode = U_AUTO;
        @(negedge clk);
        check("t3b_clr_after", timeout_err, 0);
        err_clr = 1'b0;
        wait_log("t3b", 2, 500);
        if (log_q.size() == 2) check("t3b_next_served", log_q[1], 8'h7C);
        wait_idle("t3b");

        // Reset in the middle of a transfer.
        umode = U_DEAD;
        push_item(2, 8'hD2, 1'b1);
        wait_en("t5");
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_en", uart_en, 0);
        check("t5_rst_grant", grant, 0);
        check("t5_rst_ready", req_ready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("t5_rst_data", uart_data, 0);
        umode = U_AUTO;
        log_q.delete();
        push_item(1, 8'h77, 1'b1);
        wait_log("t5", 1, 500);
        if (log_q.size() == 1) check("t5_clean_byte", log_q[0], 8'h77);
        wait_idle("t5");

        // Randomized traffic against the rotation model and scoreboard.
        gap_max = 4;
        log_q.delete();
        total = 0;
        for (int i = 0; i < NR; i++) begin
            n = $urandom_range(6, 14);
            for (int b = 0; b < n; b++)
                push_item(i, 8'($urandom), (b == n - 1) ? 1'b1 : 1'($urandom_range(0, 1)));
            total += n;
        end
        wait_log("rand", total, 20000);
        left = 0;
        for (int i = 0; i < NR; i++) left += src_q[i].size();
        check("rand_src_drained", left, 0);
        wait_idle("rand");
        check("final_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
